// File: rtl/mem_responder.sv
// Word-addressed RAM responder: one request at a time, fixed wait, then a held response.
// Optional MEM_ALIGN_CHECK_EN rejects byte addresses that are not word aligned.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          bad;
  logic          commit;
  logic [AW-1:0] idx;

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign idx       = addr_q[AW+1:2];
  assign commit    = (state == WAIT) && (cnt == '0) && !reset;

  // Rejected accesses: word index past the end (no aliasing), optionally misalignment.
`ifdef MEM_ALIGN_CHECK_EN
  assign bad = (addr_q[31:2] >= 30'(DEPTH_WORDS)) || (addr_q[1:0] != 2'b00);
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, addr_q[1:0]};
  assign bad = (addr_q[31:2] >= 30'(DEPTH_WORDS));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CW'(LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= bad;
            resp_rdata <= (we_q || bad) ? 32'h0 : mem[idx];
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is never cleared; a write lands only on the WAIT->RESP edge of an accepted request.
  always_ff @(posedge clk) begin
    if (commit && we_q && !bad) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, random traffic against a word-array model,
// and hand-written stall/reset/back-to-back sequences on a LATENCY=2 and a LATENCY=0 unit.
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [2][DEPTH];

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: word = addr/4, reject past the end (and misaligned if enabled).
  task automatic predict(input int u, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned word;
    word = addr / 4;
    err  = (word >= DEPTH);
`ifdef MEM_ALIGN_CHECK_EN
    if (addr % 4 != 0) err = 1'b1;
`endif
    rd = 32'h0;
    if (!err) begin
      if (we) mdl[u][word] = wd;
      else    rd = mdl[u][word];
    end
  endtask

  // One complete transaction with latency, hold-stability and release checks.
  task automatic txn(input int u, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int hold,
                     input bit poke, input string tag);
    int n;
    int lat;
    lat = (u == 0) ? 2 : 0;
    n = 0;
    while (!req_ready[u] && n < 20) begin tick(); n++; end
    chk({tag, " req_ready idle"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr; req_wdata[u] = wd;
    tick();
    req_valid[u] = 1'b0; req_we[u] = 1'($urandom); req_addr[u] = $urandom; req_wdata[u] = $urandom;
    n = 0;
    while (!resp_valid[u] && n < 40) begin tick(); n++; end
    chk({tag, " latency"}, 32'(n), 32'(lat + 1));
    if (!resp_valid[u]) return;
    chk({tag, " rdata"}, resp_rdata[u], exp_rd);
    chk({tag, " err"}, 32'(resp_err[u]), 32'(exp_err));
    chk({tag, " busy in resp"}, 32'(busy[u]), 32'd1);
    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        req_valid[u] = 1'b1; req_we[u] = 1'b1; req_addr[u] = 32'h30; req_wdata[u] = 32'h12345678;
      end
      tick();
      chk({tag, " hold valid"}, 32'(resp_valid[u]), 32'd1);
      chk({tag, " hold rdata"}, resp_rdata[u], exp_rd);
      chk({tag, " hold req_ready"}, 32'(req_ready[u]), 32'd0);
    end
    resp_ready[u] = 1'b1;
    tick();
    resp_ready[u] = 1'b0;
    chk({tag, " released valid"}, 32'(resp_valid[u]), 32'd0);
    chk({tag, " released req_ready"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b0;
  endtask

  task automatic model_txn(input int u, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold, input string tag);
    logic [31:0] rd;
    logic        err;
    predict(u, we, addr, wd, rd, err);
    txn(u, we, addr, wd, rd, err, hold, 1'b0, tag);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        tbl [10];
    logic [31:0] old;
    logic [31:0] rd;
    logic        err;
    int          n;

    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0; resp_ready[u] = 1'b0;
    end
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < int'(DEPTH); w++) mdl[u][w] = 32'h0;
    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      chk("reset req_ready", 32'(req_ready[u]), 32'd0);
      chk("reset resp_valid", 32'(resp_valid[u]), 32'd0);
      chk("reset busy", 32'(busy[u]), 32'd0);
      chk("reset rdata", resp_rdata[u], 32'h0);
      chk("reset err", 32'(resp_err[u]), 32'd0);
      reset[u] = 1'b0;
    end
    #1;
    for (int u = 0; u < 2; u++) chk("post-reset req_ready", 32'(req_ready[u]), 32'd1);

    // Preload known contents: word i holds C0DE0000|i.
    for (int w = 0; w < 16; w++) model_txn(0, 1'b1, 32'(w * 4), 32'hC0DE0000 | 32'(w), 0, "pre0");
    for (int w = 0; w < 2; w++)  model_txn(1, 1'b1, 32'(w * 4), 32'hBEEF0000 | 32'(w), 0, "pre1");

    tbl[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
    tbl[3] = '{1'b1, 32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[4] = '{1'b0, 32'h0,    32'h0,        32'hC0DE0000, 1'b0};
    tbl[5] = '{1'b1, 32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0};
    tbl[6] = '{1'b0, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
    tbl[7] = '{1'b0, 32'h12,   32'h0,        32'h0,        1'b1};
    tbl[8] = '{1'b1, 32'h7,    32'h11111111, 32'h0,        1'b1};
    tbl[9] = '{1'b0, 32'h4,    32'h0,        32'hC0DE0001, 1'b0};
`else
    tbl[7] = '{1'b0, 32'h12,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[8] = '{1'b1, 32'h7,    32'h11111111, 32'h0,        1'b0};
    tbl[9] = '{1'b0, 32'h4,    32'h0,        32'h11111111, 1'b0};
`endif
    for (int i = 0; i < 10; i++) begin
      predict(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, err);
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err,
          i % 2, 1'b0, $sformatf("tbl%0d", i));
    end

    // Stall with a new request presented during the response: it must be ignored.
    old = mdl[0][12];
    predict(0, 1'b0, 32'h10, 32'h0, rd, err);
    txn(0, 1'b0, 32'h10, 32'h0, rd, err, 5, 1'b1, "stall");
    model_txn(0, 1'b0, 32'h30, 32'h0, 0, "poke ignored");
    chk("poke word unchanged", mdl[0][12], old);

    // Reset while in WAIT discards the write.
    old = mdl[0][8];
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h55;
    tick();
    req_valid[0] = 1'b0; reset[0] = 1'b1;
    #1;
    chk("rst wait req_ready", 32'(req_ready[0]), 32'd0);
    tick();
    chk("rst wait busy", 32'(busy[0]), 32'd0);
    chk("rst wait resp_valid", 32'(resp_valid[0]), 32'd0);
    reset[0] = 1'b0;
    #1;
    chk("rst wait ready after", 32'(req_ready[0]), 32'd1);
    resp_ready[0] = 1'b1;
    repeat (4) tick();
    resp_ready[0] = 1'b0;
    chk("rst wait no resp", 32'(resp_valid[0]), 32'd0);
    model_txn(0, 1'b0, 32'h20, 32'h0, 0, "rst wait readback");
    chk("rst wait old kept", mdl[0][8], old);

    // Reset coinciding with a presented request: nothing accepted.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h77;
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0; req_valid[0] = 1'b0;
    chk("rst hs busy", 32'(busy[0]), 32'd0);
    repeat (4) tick();
    chk("rst hs no resp", 32'(resp_valid[0]), 32'd0);
    model_txn(0, 1'b0, 32'h20, 32'h0, 0, "rst hs readback");

    // Reset during RESP drops the pending response.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 20) begin tick(); n++; end
    chk("rst resp reached", 32'(resp_valid[0]), 32'd1);
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    chk("rst resp dropped", 32'(resp_valid[0]), 32'd0);
    chk("rst resp idle", 32'(busy[0]), 32'd0);

    // LATENCY=0 back-to-back reads with resp_ready tied high.
    resp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0;
    tick();
    req_addr[1] = 32'h4;
    tick();
    chk("b2b resp0 valid", 32'(resp_valid[1]), 32'd1);
    chk("b2b resp0 data", resp_rdata[1], mdl[1][0]);
    tick();
    chk("b2b gap valid", 32'(resp_valid[1]), 32'd0);
    chk("b2b gap ready", 32'(req_ready[1]), 32'd1);
    tick();
    req_valid[1] = 1'b0;
    chk("b2b second busy", 32'(busy[1]), 32'd1);
    tick();
    chk("b2b resp1 valid", 32'(resp_valid[1]), 32'd1);
    chk("b2b resp1 data", resp_rdata[1], mdl[1][1]);
    tick();
    resp_ready[1] = 1'b0;
    chk("b2b done", 32'(resp_valid[1]), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      int u;
      logic we;
      logic [31:0] addr;
      u  = i % 2;
      we = 1'($urandom);
      if ($urandom % 8 == 0)
        addr = 32'($urandom_range(32'h3FFFFFFF, DEPTH)) << 2;
      else
        addr = 32'($urandom_range(u == 0 ? 15 : 1, 0)) << 2;
      if ($urandom % 4 == 0) addr = addr | 32'($urandom % 4);
      model_txn(u, we, addr, $urandom, int'($urandom % 3), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
